// File: rtl/mac_pkg.sv
// Shared types and helpers for the multi-bank MAC: FSM states, pipeline depth,
// and the saturating add used when MAC_ACC_SATURATE_EN is defined.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } mac_state_e;

    localparam int PIPE_DEPTH    = 2;
    localparam int MAX_ACC_WIDTH = 64;

    // Two guard bits so any pair of ACC_WIDTH operands (up to 64 bits) sums exactly.
    typedef logic signed [MAX_ACC_WIDTH+1:0] wide_t;

    // Returns {clamped, result}; only the low 'width' bits of result are meaningful.
    function automatic logic [MAX_ACC_WIDTH:0] sat_add(input wide_t a,
                                                       input wide_t b,
                                                       input int    width,
                                                       input logic  isSigned);
        wide_t sum;
        wide_t hi;
        wide_t lo;
        logic  clamp;
        sum = a + b;
        if (isSigned) begin
            hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
            lo = -(wide_t'(1) <<< (width - 1));
        end else begin
            hi = (wide_t'(1) <<< width) - wide_t'(1);
            lo = '0;
        end
        clamp = 1'b0;
        if (sum > hi) begin
            sum   = hi;
            clamp = 1'b1;
        end else if (sum < lo) begin
            sum   = lo;
            clamp = 1'b1;
        end
        return {clamp, sum[MAX_ACC_WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// Stage 1 of the MAC pipeline: registered DATA_WIDTH x DATA_WIDTH multiply,
// signed or unsigned, extended to the accumulator width.
module mac_mul_stage
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SEL_WIDTH  = 2,
    parameter int SIGNED     = 0
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_act,
    input  logic [DATA_WIDTH-1:0] i_weight,
    input  logic [SEL_WIDTH-1:0]  i_sel,
    input  logic                  i_first,
    output logic                  o_valid,
    output logic [ACC_WIDTH-1:0]  o_product,
    output logic [SEL_WIDTH-1:0]  o_sel,
    output logic                  o_first
);

    logic                 r_valid;
    logic [ACC_WIDTH-1:0] r_product;
    logic [SEL_WIDTH-1:0] r_sel;
    logic                 r_first;
    logic [ACC_WIDTH-1:0] w_product;

    // Operands are widened before the multiply so the full 2*DATA_WIDTH product is kept.
    if (SIGNED != 0) begin : g_signed
        logic signed [2*DATA_WIDTH-1:0] w_prodS;
        assign w_prodS   = (2*DATA_WIDTH)'($signed(i_act)) * (2*DATA_WIDTH)'($signed(i_weight));
        assign w_product = ACC_WIDTH'(w_prodS);
    end else begin : g_unsigned
        logic [2*DATA_WIDTH-1:0] w_prodU;
        assign w_prodU   = (2*DATA_WIDTH)'(i_act) * (2*DATA_WIDTH)'(i_weight);
        assign w_product = ACC_WIDTH'(w_prodU);
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_product <= '0;
            r_sel     <= '0;
            r_first   <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_product <= w_product;
                r_sel     <= i_sel;
                r_first   <= i_first;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_product = r_product;
    assign o_sel     = r_sel;
    assign o_first   = r_first;

endmodule

// File: rtl/mac_bank_acc.sv
// N-bank multiply-accumulate with valid/ready input, two-stage pipeline and
// sequential drain port. Define MAC_ACC_SATURATE_EN for saturating banks with sticky ovf.
module mac_bank_acc
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_BANKS  = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_BANKS),
    parameter int SIGNED     = 0
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_act,
    input  logic [DATA_WIDTH-1:0] in_weight,
    input  logic [SEL_WIDTH-1:0]  in_sel,
    input  logic                  in_first,
    input  logic                  drain_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_WIDTH-1:0]  out_bank,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_ovf,
    output logic                  busy
);

    mac_state_e           r_state;
    mac_state_e           w_nextState;
    logic [1:0]           r_flushCnt;
    logic [SEL_WIDTH-1:0] r_idx;
    logic [ACC_WIDTH-1:0] r_bank [NUM_BANKS];

    logic                 w_accept;
    logic                 w_s1Valid;
    logic [ACC_WIDTH-1:0] w_s1Product;
    logic [SEL_WIDTH-1:0] w_s1Sel;
    logic                 w_s1First;

    logic                 r_s2Valid;
    logic [ACC_WIDTH-1:0] r_s2Product;
    logic [SEL_WIDTH-1:0] r_s2Sel;
    logic                 r_s2First;

    logic                 w_drainLast;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH-1:0] w_newVal;
    logic                 w_ovfOut;

    assign w_accept    = in_valid && in_ready;
    assign w_drainLast = (r_state == DRAIN) && out_ready && (r_idx == SEL_WIDTH'(NUM_BANKS - 1));
    assign w_base      = r_s2First ? '0 : r_bank[r_s2Sel];

    mac_mul_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SEL_WIDTH (SEL_WIDTH),
        .SIGNED    (SIGNED)
    ) u_mul (
        .Clk      (Clk),
        .rst      (rst),
        .i_valid  (w_accept),
        .i_act    (in_act),
        .i_weight (in_weight),
        .i_sel    (in_sel),
        .i_first  (in_first),
        .o_valid  (w_s1Valid),
        .o_product(w_s1Product),
        .o_sel    (w_s1Sel),
        .o_first  (w_s1First)
    );

    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_s2Valid   <= 1'b0;
            r_s2Product <= '0;
            r_s2Sel     <= '0;
            r_s2First   <= 1'b0;
        end else begin
            r_s2Valid <= w_s1Valid;
            if (w_s1Valid) begin
                r_s2Product <= w_s1Product;
                r_s2Sel     <= w_s1Sel;
                r_s2First   <= w_s1First;
            end
        end
    end

`ifdef MAC_ACC_SATURATE_EN
    logic                   r_ovf [NUM_BANKS];
    wide_t                  w_baseWide;
    wide_t                  w_prodWide;
    logic [MAX_ACC_WIDTH:0] w_satRes;

    if (SIGNED != 0) begin : g_extSigned
        assign w_baseWide = wide_t'($signed(w_base));
        assign w_prodWide = wide_t'($signed(r_s2Product));
    end else begin : g_extUnsigned
        assign w_baseWide = wide_t'(w_base);
        assign w_prodWide = wide_t'(r_s2Product);
    end

    assign w_satRes = sat_add(w_baseWide, w_prodWide, ACC_WIDTH, SIGNED != 0);
    assign w_newVal = w_satRes[ACC_WIDTH-1:0];
    assign w_ovfOut = r_ovf[r_idx];

    // A restart drops the old sticky flag; a clamp on the loaded value still sets it.
    always_ff @(posedge Clk) begin
        if (!rst || w_drainLast) begin
            for (int i = 0; i < NUM_BANKS; i++) r_ovf[i] <= 1'b0;
        end else if (r_s2Valid) begin
            r_ovf[r_s2Sel] <= (r_s2First ? 1'b0 : r_ovf[r_s2Sel]) | w_satRes[MAX_ACC_WIDTH];
        end
    end
`else
    assign w_newVal = w_base + r_s2Product;
    assign w_ovfOut = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!rst || w_drainLast) begin
            for (int i = 0; i < NUM_BANKS; i++) r_bank[i] <= '0;
        end else if (r_s2Valid) begin
            r_bank[r_s2Sel] <= w_newVal;
        end
    end

    always_ff @(posedge Clk) begin
        if (!rst) begin
            r_state    <= ACCUM;
            r_flushCnt <= 2'd0;
            r_idx      <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state != FLUSH) begin
                r_flushCnt <= 2'd0;
            end else if (r_flushCnt != 2'(PIPE_DEPTH)) begin
                r_flushCnt <= r_flushCnt + 2'd1;
            end
            if ((r_state == DRAIN) && out_ready) begin
                r_idx <= w_drainLast ? '0 : r_idx + SEL_WIDTH'(1);
            end
        end
    end

    // FLUSH always waits the full pipeline depth so drain latency is fixed.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_bank    = '0;
        out_data    = '0;
        out_ovf     = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (drain_req) w_nextState = FLUSH;
            end
            FLUSH: begin
                if ((r_flushCnt == 2'(PIPE_DEPTH)) && !w_s1Valid && !r_s2Valid) w_nextState = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_bank  = r_idx;
                out_data  = r_bank[r_idx];
                out_ovf   = w_ovfOut;
                if (w_drainLast) w_nextState = ACCUM;
            end
            default: w_nextState = ACCUM;
        endcase
    end

    assign busy = (r_state != ACCUM) || w_s1Valid || r_s2Valid;

endmodule

// File: tb/tb_mac_bank_acc.sv
// Scoreboard bench for mac_bank_acc: three configurations (unsigned/32, signed/32,
// unsigned/16) share one stimulus stream; drained words are checked against hand values.
module tb_mac_bank_acc;

    logic        Clk = 1'b0;
    logic        rst = 1'b0;
    logic        inValid = 1'b0;
    logic [7:0]  inAct = '0;
    logic [7:0]  inWeight = '0;
    logic [1:0]  inSel = '0;
    logic        inFirst = 1'b0;
    logic        drainReq = 1'b0;
    logic        outReady = 1'b1;

    logic        u0InReady, u0OutValid, u0OutOvf, u0Busy;
    logic [1:0]  u0OutBank;
    logic [31:0] u0OutData;
    logic        u1InReady, u1OutValid, u1OutOvf, u1Busy;
    logic [1:0]  u1OutBank;
    logic [31:0] u1OutData;
    logic        u2InReady, u2OutValid, u2OutOvf, u2Busy;
    logic [1:0]  u2OutBank;
    logic [15:0] u2OutData;

`ifdef MAC_ACC_SATURATE_EN
    localparam logic [15:0] SAT_D2   = 16'd65535;
    localparam logic        SAT_OVF2 = 1'b1;
`else
    localparam logic [15:0] SAT_D2   = 16'd64514;
    localparam logic        SAT_OVF2 = 1'b0;
`endif

    typedef struct {
        logic [1:0]  bank;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [15:0] d2;
        logic        ovf2;
    } expWord_t;

    expWord_t expQ[$];
    int checkCnt = 0;
    int passCnt  = 0;

    always #5 Clk = ~Clk;

    mac_bank_acc #(.DATA_WIDTH(8), .ACC_WIDTH(32), .NUM_BANKS(4), .SIGNED(0)) u0 (
        .Clk(Clk), .rst(rst), .in_valid(inValid), .in_ready(u0InReady), .in_act(inAct),
        .in_weight(inWeight), .in_sel(inSel), .in_first(inFirst), .drain_req(drainReq),
        .out_valid(u0OutValid), .out_ready(outReady), .out_bank(u0OutBank),
        .out_data(u0OutData), .out_ovf(u0OutOvf), .busy(u0Busy));

    mac_bank_acc #(.DATA_WIDTH(8), .ACC_WIDTH(32), .NUM_BANKS(4), .SIGNED(1)) u1 (
        .Clk(Clk), .rst(rst), .in_valid(inValid), .in_ready(u1InReady), .in_act(inAct),
        .in_weight(inWeight), .in_sel(inSel), .in_first(inFirst), .drain_req(drainReq),
        .out_valid(u1OutValid), .out_ready(outReady), .out_bank(u1OutBank),
        .out_data(u1OutData), .out_ovf(u1OutOvf), .busy(u1Busy));

    mac_bank_acc #(.DATA_WIDTH(8), .ACC_WIDTH(16), .NUM_BANKS(4), .SIGNED(0)) u2 (
        .Clk(Clk), .rst(rst), .in_valid(inValid), .in_ready(u2InReady), .in_act(inAct),
        .in_weight(inWeight), .in_sel(inSel), .in_first(inFirst), .drain_req(drainReq),
        .out_valid(u2OutValid), .out_ready(outReady), .out_bank(u2OutBank),
        .out_data(u2OutData), .out_ovf(u2OutOvf), .busy(u2Busy));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCnt++;
        if (actual === expected) passCnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Caller sits #1 after a rising edge; returns #1 after the edge that accepted the sample.
    task automatic applyStimulus(input logic [7:0] act, input logic [7:0] wgt,
                                 input logic [1:0] sel, input logic first);
        inAct    = act;
        inWeight = wgt;
        inSel    = sel;
        inFirst  = first;
        inValid  = 1'b1;
        @(posedge Clk);
        #1;
        inValid = 1'b0;
        inFirst = 1'b0;
    endtask

    task automatic pushExp(input logic [1:0] bank, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [15:0] d2, input logic ovf2);
        expWord_t e;
        e.bank = bank;
        e.d0   = d0;
        e.d1   = d1;
        e.d2   = d2;
        e.ovf2 = ovf2;
        expQ.push_back(e);
    endtask

    task automatic issueDrain(input logic withSample);
        drainReq = 1'b1;
        if (withSample) begin
            inAct    = 8'd1;
            inWeight = 8'd1;
            inSel    = 2'd2;
            inValid  = 1'b1;
        end
        @(posedge Clk);
        #1;
        drainReq = 1'b0;
        inValid  = 1'b0;
    endtask

    task automatic waitDrain(input logic toggle);
        int cyc;
        cyc = 0;
        forever begin
            @(negedge Clk);
            #1;
            if (expQ.size() == 0) break;
            checkOutput("in_ready_while_busy", {31'b0, u0InReady}, 32'd0);
            cyc++;
            if (cyc > 100) begin
                checkOutput("drain_timeout", 32'd1, 32'd0);
                expQ.delete();
                break;
            end
            @(posedge Clk);
            #1;
            if (toggle) outReady = ~outReady;
        end
        @(posedge Clk);
        #1;
        outReady = 1'b1;
        @(negedge Clk);
        checkOutput("busy_after_drain", {29'b0, u0Busy, u1Busy, u2Busy}, 32'd0);
        checkOutput("ready_after_drain", {29'b0, u0InReady, u1InReady, u2InReady}, 32'd7);
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor: pops one expected word per accepted drain beat.
    logic        heldValid = 1'b0;
    logic [31:0] heldData;
    logic [1:0]  heldBank;
    always @(negedge Clk) begin
        expWord_t e;
        if (!rst) begin
            heldValid = 1'b0;
        end else begin
            if (u0OutValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_word", {30'b0, u0OutBank}, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("u0_bank", {30'b0, u0OutBank}, {30'b0, e.bank});
                    checkOutput("u0_data", u0OutData, e.d0);
                    checkOutput("u0_ovf", {31'b0, u0OutOvf}, 32'd0);
                    checkOutput("u1_valid", {31'b0, u1OutValid}, 32'd1);
                    checkOutput("u1_data", u1OutData, e.d1);
                    checkOutput("u1_ovf", {31'b0, u1OutOvf}, 32'd0);
                    checkOutput("u2_bank", {30'b0, u2OutBank}, {30'b0, e.bank});
                    checkOutput("u2_data", {16'b0, u2OutData}, {16'b0, e.d2});
                    checkOutput("u2_ovf", {31'b0, u2OutOvf}, {31'b0, e.ovf2});
                end
            end
            if (!u0OutValid) begin
                checkOutput("idle_outputs_zero", u0OutData | {30'b0, u0OutBank} | {31'b0, u0OutOvf}, 32'd0);
            end
            if (heldValid) begin
                checkOutput("hold_valid", {31'b0, u0OutValid}, 32'd1);
                checkOutput("hold_data", u0OutData, heldData);
                checkOutput("hold_bank", {30'b0, u0OutBank}, {30'b0, heldBank});
            end
            heldValid = u0OutValid && !outReady;
            heldData  = u0OutData;
            heldBank  = u0OutBank;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        rst = 1'b1;
        @(negedge Clk);
        checkOutput("reset_in_ready", {29'b0, u0InReady, u1InReady, u2InReady}, 32'd7);
        checkOutput("reset_out_valid", {29'b0, u0OutValid, u1OutValid, u2OutValid}, 32'd0);
        checkOutput("reset_out_data", u0OutData, 32'd0);
        checkOutput("reset_out_bank_ovf", {29'b0, u0OutBank, u0OutOvf}, 32'd0);
        checkOutput("reset_busy", {29'b0, u0Busy, u1Busy, u2Busy}, 32'd0);
        @(posedge Clk);
        #1;

        // 3x4 four times into every bank, then drain with fixed latency check
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++) applyStimulus(8'd3, 8'd4, 2'(b), 1'b0);
        for (int b = 0; b < 4; b++) pushExp(2'(b), 32'd48, 32'd48, 16'd48, 1'b0);
        issueDrain(1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            checkOutput($sformatf("drain_latency_%0d", k), {31'b0, u0OutValid}, (k == 3) ? 32'd1 : 32'd0);
        end
        waitDrain(1'b0);

        // Mixed-sign operands into bank 1
        applyStimulus(8'hFB, 8'd7, 2'd1, 1'b0);
        applyStimulus(8'd2, 8'd3, 2'd1, 1'b0);
        pushExp(2'd0, 32'd0, 32'd0, 16'd0, 1'b0);
        pushExp(2'd1, 32'd1763, 32'hFFFF_FFE3, 16'd1763, 1'b0);
        pushExp(2'd2, 32'd0, 32'd0, 16'd0, 1'b0);
        pushExp(2'd3, 32'd0, 32'd0, 16'd0, 1'b0);
        issueDrain(1'b0);
        waitDrain(1'b0);

        // Back-to-back same bank, restart on the third sample
        applyStimulus(8'd2, 8'd2, 2'd3, 1'b0);
        applyStimulus(8'd2, 8'd2, 2'd3, 1'b0);
        applyStimulus(8'd2, 8'd2, 2'd3, 1'b1);
        @(negedge Clk);
        checkOutput("busy_pipeline", {31'b0, u0Busy}, 32'd1);
        checkOutput("ready_pipeline", {31'b0, u0InReady}, 32'd1);
        @(posedge Clk);
        #1;
        for (int b = 0; b < 3; b++) pushExp(2'(b), 32'd0, 32'd0, 16'd0, 1'b0);
        pushExp(2'd3, 32'd4, 32'd4, 16'd4, 1'b0);
        issueDrain(1'b0);
        waitDrain(1'b0);

        // Sample accepted with drain_req; out_ready toggles during drain
        pushExp(2'd0, 32'd0, 32'd0, 16'd0, 1'b0);
        pushExp(2'd1, 32'd0, 32'd0, 16'd0, 1'b0);
        pushExp(2'd2, 32'd1, 32'd1, 16'd1, 1'b0);
        pushExp(2'd3, 32'd0, 32'd0, 16'd0, 1'b0);
        issueDrain(1'b1);
        waitDrain(1'b1);

        // 255x255 twice into bank 0: overflows only the 16-bit unit
        applyStimulus(8'd255, 8'd255, 2'd0, 1'b0);
        applyStimulus(8'd255, 8'd255, 2'd0, 1'b0);
        pushExp(2'd0, 32'd130050, 32'd2, SAT_D2, SAT_OVF2);
        for (int b = 1; b < 4; b++) pushExp(2'(b), 32'd0, 32'd0, 16'd0, 1'b0);
        issueDrain(1'b0);
        waitDrain(1'b0);

        // Reset while drain sits at bank 2; partial sums must be lost
        for (int b = 0; b < 4; b++) applyStimulus(8'd1, 8'd1, 2'(b), 1'b0);
        pushExp(2'd0, 32'd1, 32'd1, 16'd1, 1'b0);
        pushExp(2'd1, 32'd1, 32'd1, 16'd1, 1'b0);
        issueDrain(1'b0);
        begin
            int cyc;
            cyc = 0;
            forever begin
                @(negedge Clk);
                #1;
                if (expQ.size() == 0) break;
                cyc++;
                if (cyc > 100) begin
                    checkOutput("partial_drain_timeout", 32'd1, 32'd0);
                    expQ.delete();
                    break;
                end
            end
        end
        @(posedge Clk);
        #1;
        outReady = 1'b0;
        checkOutput("drain_at_bank2", {29'b0, u0OutValid, u0OutBank}, 32'd6);
        rst = 1'b0;
        @(posedge Clk);
        #1;
        rst = 1'b1;
        @(negedge Clk);
        checkOutput("abort_out_valid", {29'b0, u0OutValid, u1OutValid, u2OutValid}, 32'd0);
        checkOutput("abort_busy", {31'b0, u0Busy}, 32'd0);
        checkOutput("abort_in_ready", {31'b0, u0InReady}, 32'd1);
        @(posedge Clk);
        #1;
        outReady = 1'b1;
        for (int b = 0; b < 4; b++) pushExp(2'(b), 32'd0, 32'd0, 16'd0, 1'b0);
        issueDrain(1'b0);
        waitDrain(1'b0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/mac_bank_acc.md
# mac_bank_acc

Parametrised multi-bank multiply-accumulate unit: the next generation of the team's 4-bank 8-bit MAC, generalised to N banks, signed or unsigned operands, and configurable accumulator width. It adds a valid/ready input handshake, a two-stage pipeline, per-bank restart, and a sequential drain port. Sits inside each PE, between the sparse-index decoder (act/weight/bank select) and the partial-sum collector.

## Interface
- DATA_WIDTH, 8, operand width (act and weight)
- ACC_WIDTH, 32, accumulator width per bank; must be ≥ 2*DATA_WIDTH
- NUM_BANKS, 4, number of accumulator banks; power of two, ≥ 2
- SEL_WIDTH, $clog2(NUM_BANKS), bank index width
- SIGNED, 0, 1 = two's-complement operands and accumulators; 0 = unsigned
- Clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  unit accepts a sample this cycle
- in_act  in  DATA_WIDTH  activation operand
- in_weight  in  DATA_WIDTH  weight operand
- in_sel  in  SEL_WIDTH  target bank
- in_first  in  1  bank restart: accumulator replaced by the product instead of accumulated into
- drain_req  in  1  request readout of all banks
- out_valid  out  1  drain word valid
- out_ready  in  1  downstream accepts drain word
- out_bank  out  SEL_WIDTH  bank index of out_data
- out_data  out  ACC_WIDTH  bank value
- out_ovf  out  1  sticky overflow flag of that bank
- busy  out  1  high in any state other than ACCUM, or while the pipeline holds data

## Operation
- FSM states: ACCUM, FLUSH, DRAIN.
- ACCUM: in_ready=1. A sample is accepted when in_valid && in_ready.
- Stage 1 registers product, sel, first, and a valid bit. Product is signed or unsigned per SIGNED, 2*DATA_WIDTH bits, extended to ACC_WIDTH (sign-extended if SIGNED).
- Stage 2 writes bank[sel] = first ? product : bank[sel] + product. Read-modify-write completes in one cycle, so back-to-back samples to the same bank need no stall.
- drain_req high in ACCUM → FLUSH next cycle. A sample accepted in that same cycle is included in the drain.
- FLUSH: in_ready=0. Remains until both pipeline stages are empty (exactly 2 cycles), then → DRAIN with idx=0.
- DRAIN: out_valid=1, out_bank=idx, out_data=bank[idx], out_ovf=ovf[idx]. On out_ready, idx increments. On the handshake at idx=NUM_BANKS-1, all banks and ovf flags clear and the FSM returns to ACCUM next cycle.
- drain_req is ignored outside ACCUM. out_valid is 0 outside DRAIN; out_data, out_bank, and out_ovf are 0 when out_valid=0.
- in_first with in_valid=0 has no effect.

## Timing
- Reset (rst=0 at an edge): all banks=0, ovf=0, pipeline valids=0, FSM=ACCUM, idx=0. Outputs: in_ready=1 after the reset edge; out_valid=0, out_data=0, out_bank=0, out_ovf=0, busy=0.
- Reset mid-FLUSH or mid-DRAIN aborts the operation. All partial sums are lost, with no further output.
- Latency: a sample accepted at edge t is in its bank after edge t+2. The first drain word is valid 3 cycles after the edge where drain_req is sampled.
- Drain throughput: one bank per cycle with out_ready held high. out_valid holds and data is stable while out_ready=0.
- Arithmetic wraps modulo 2^ACC_WIDTH unless saturation is compiled in.

## Configuration
- MAC_ACC_SATURATE_EN defined: stage-2 add saturates to the max/min of ACC_WIDTH (signed or unsigned range per SIGNED), and the bank's ovf flag sets sticky on any clamp. in_first clears ovf before loading.
- Undefined: wrap-around add; ovf registers are not built; out_ovf is tied to 0.

## Structure
- Shared package mac_pkg: FSM state enum (ACCUM, FLUSH, DRAIN), PIPE_DEPTH=2 constant, and a saturating-add function used when MAC_ACC_SATURATE_EN is defined.
- One sub-module, mac_mul_stage: registered multiplier (stage 1) with signed/unsigned selection and extension to ACC_WIDTH.

## Test plan
- Reset, then accumulate act=3, weight=4 to banks 0..3, four samples each, then drain with out_ready=1 → out_data=48 for banks 0..3 on 4 consecutive cycles; busy drops after the return to ACCUM.
- SIGNED=1: act=-5, weight=7 to bank 1, then act=2, weight=3 to bank 1 → drained bank 1 = -29; other banks = 0.
- Back-to-back same-bank samples with in_first on the 3rd of 3 (each 2×2) → bank value 4.
- drain_req in the same cycle as an accepted sample (act=1, weight=1, bank 2) → that sample is included; in_ready=0 for FLUSH plus drain; out_ready toggled 1/0 → each word holds stable until accepted.
- MAC_ACC_SATURATE_EN, ACC_WIDTH=16, unsigned, repeated 255×255 to bank 0 → saturates at 65535, out_ovf=1. Without the macro → value wraps, out_ovf=0.
- rst=0 asserted during DRAIN at idx=2 → out_valid=0 next cycle; a subsequent drain returns all zeros.
